// File: rtl/fft_frame_feeder.sv
// Ping-pong frame capture feeding an FFT core over AXI4-Stream (config + data channels).
// Optional build macro FEEDER_DC_REMOVE_EN subtracts the previous frame's mean from each sample.
module fft_frame_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int FFT_LEN    = 1024,
  parameter int LOG2_LEN   = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sample_valid,
  input  logic [DATA_WIDTH-1:0]   sample_data,
  input  logic                    fft_mode,
  output logic                    xn_axi4s_cfg_tvalid,
  output logic                    xn_axi4s_cfg_tdata,
  input  logic                    xn_axi4s_cfg_tready,
  output logic                    xn_axi4s_data_tvalid,
  output logic [2*DATA_WIDTH-1:0] xn_axi4s_data_tdata,
  output logic                    xn_axi4s_data_tlast,
  input  logic                    xn_axi4s_data_tready,
  output logic                    overflow,
  input  logic                    clear_ovf,
  output logic                    frame_done
);

`ifdef FEEDER_DC_REMOVE_EN
  localparam int SKID = 3;  // one extra slot covers the extra pipeline stage at full rate
`else
  localparam int SKID = 2;
`endif

  typedef enum logic [1:0] {IDLE, CFG, PRIME, STREAM} state_t;

  logic [DATA_WIDTH-1:0] mem [2*FFT_LEN];
  logic [1:0]            full;
  logic                  wr_bank;
  logic [LOG2_LEN-1:0]   wr_ptr;
  logic                  cap, drop, wrap;

  state_t                state_q, state_d;
  logic                  rd_bank, rd_next, mode_q, sel;
  logic [LOG2_LEN:0]     rd_cnt;
  logic                  rd_en;
  logic [1:0]            cnt, inflight;
  logic [2:0]            occ;
  logic                  push, pop, frame_end, push_last;
  logic [DATA_WIDTH-1:0] push_data;
  logic [DATA_WIDTH-1:0] data_p1;
  logic                  vld_p1, last_p1;
  logic [DATA_WIDTH-1:0] skid_data [4];
  logic                  skid_last [4];

  assign drop = sample_valid & full[wr_bank];
  assign cap  = sample_valid & ~full[wr_bank];
  assign wrap = cap & (wr_ptr == LOG2_LEN'(FFT_LEN - 1));

  assign pop       = xn_axi4s_data_tvalid & xn_axi4s_data_tready;
  assign frame_end = pop & skid_last[0];
  // Occupancy the skid buffer will reach once everything already in flight lands.
  assign occ   = 3'(cnt) + 3'(inflight) - 3'(pop);
  assign rd_en = ((state_q == PRIME) || (state_q == STREAM)) && !rd_cnt[LOG2_LEN]
                 && (occ < 3'(SKID));

  always_comb begin
    state_d             = state_q;
    sel                 = 1'b0;
    xn_axi4s_cfg_tvalid = 1'b0;
    case (state_q)
      IDLE:   if (full[rd_next]) begin
                sel     = 1'b1;
                state_d = CFG;
              end
      CFG:    begin
                xn_axi4s_cfg_tvalid = 1'b1;
                if (xn_axi4s_cfg_tready) state_d = PRIME;
              end
      PRIME:  if (cnt != 2'd0) state_d = STREAM;
      STREAM: if (frame_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign xn_axi4s_cfg_tdata   = xn_axi4s_cfg_tvalid & mode_q;
  assign xn_axi4s_data_tvalid = (state_q == STREAM) && (cnt != 2'd0);
  assign xn_axi4s_data_tdata  = xn_axi4s_data_tvalid ? {{DATA_WIDTH{1'b0}}, skid_data[0]} : '0;
  assign xn_axi4s_data_tlast  = xn_axi4s_data_tvalid & skid_last[0];
  assign frame_done           = frame_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      full     <= 2'b00;
      wr_bank  <= 1'b0;
      wr_ptr   <= '0;
      overflow <= 1'b0;
      rd_bank  <= 1'b0;
      rd_next  <= 1'b0;
      mode_q   <= 1'b0;
      rd_cnt   <= '0;
      cnt      <= 2'd0;
      vld_p1   <= 1'b0;
      last_p1  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cap) wr_ptr <= wr_ptr + 1'b1;
      if (wrap) begin
        full[wr_bank] <= 1'b1;
        wr_bank       <= ~wr_bank;
      end
      if (frame_end) begin
        full[rd_bank] <= 1'b0;
        rd_next       <= ~rd_next;
      end
      if (drop)           overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
      if (sel) begin
        rd_bank <= rd_next;
        mode_q  <= fft_mode;
        rd_cnt  <= '0;
      end else if (rd_en) begin
        rd_cnt <= rd_cnt + 1'b1;
      end
      cnt     <= cnt + 2'(push) - 2'(pop);
      vld_p1  <= rd_en;
      last_p1 <= rd_en && (rd_cnt[LOG2_LEN-1:0] == LOG2_LEN'(FFT_LEN - 1));
    end
  end

  // Frame storage: write port for capture, registered read port for the streamer.
  always_ff @(posedge clk) begin
    if (cap)   mem[{wr_bank, wr_ptr}] <= sample_data;
    if (rd_en) data_p1 <= mem[{rd_bank, rd_cnt[LOG2_LEN-1:0]}];
  end

  // Skid buffer: entry 0 is the presented beat, it only moves on a handshake.
  always_ff @(posedge clk) begin
    if (pop) begin
      for (int i = 0; i < 3; i++) begin
        skid_data[i] <= skid_data[i+1];
        skid_last[i] <= skid_last[i+1];
      end
    end
    if (push) begin
      skid_data[cnt - 2'(pop)] <= push_data;
      skid_last[cnt - 2'(pop)] <= push_last;
    end
  end

`ifdef FEEDER_DC_REMOVE_EN
  logic signed [DATA_WIDTH+LOG2_LEN-1:0] acc, acc_sum;
  logic signed [DATA_WIDTH-1:0]          last_mean;
  logic signed [DATA_WIDTH-1:0]          bank_sub [2];
  logic        [DATA_WIDTH-1:0]          data_p2;
  logic                                  vld_p2, last_p2;

  function automatic logic [DATA_WIDTH-1:0] sat(input logic signed [DATA_WIDTH:0] x);
    if (x[DATA_WIDTH] != x[DATA_WIDTH-1])
      return x[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    return x[DATA_WIDTH-1:0];
  endfunction

  assign acc_sum = acc + (DATA_WIDTH+LOG2_LEN)'(signed'(sample_data));

  // Each bank keeps the mean of the frame captured before it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      last_mean   <= '0;
      bank_sub[0] <= '0;
      bank_sub[1] <= '0;
      vld_p2      <= 1'b0;
      last_p2     <= 1'b0;
    end else begin
      if (cap) begin
        if (wrap) begin
          acc               <= '0;
          last_mean         <= DATA_WIDTH'(acc_sum >>> LOG2_LEN);
          bank_sub[wr_bank] <= last_mean;
        end else begin
          acc <= acc_sum;
        end
      end
      vld_p2  <= vld_p1;
      last_p2 <= last_p1;
    end
  end

  // Stage p2: mean removal with saturation
  always_ff @(posedge clk) begin
    data_p2 <= sat({data_p1[DATA_WIDTH-1], data_p1}
                   - {bank_sub[rd_bank][DATA_WIDTH-1], bank_sub[rd_bank]});
  end

  assign push      = vld_p2;
  assign push_data = data_p2;
  assign push_last = last_p2;
  assign inflight  = {1'b0, vld_p1} + {1'b0, vld_p2};
`else
  assign push      = vld_p1;
  assign push_data = data_p1;
  assign push_last = last_p1;
  assign inflight  = {1'b0, vld_p1};
`endif

endmodule
